// File: rtl/cache_miss_handler.sv
// Miss-service engine: victim select, optional dirty write-back, line fill, tag install.
// Define CMH_WRITEBACK_EN to build the write-back path; leave it undefined for write-through caches.
module cache_miss_handler #(
    parameter int INDEX_WIDTH  = 8,
    parameter int SET_WIDTH    = 2,
    parameter int OFFSET_WIDTH = 2,
    parameter int TAG_WIDTH    = 6,
    parameter int WORD_WIDTH   = 16,
    localparam int ADDR_WIDTH  = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   miss_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    repl_en,
    output logic                    repl_update,
    output logic                    repl_hit,
    output logic [INDEX_WIDTH-1:0]  repl_index,
    input  logic [SET_WIDTH-1:0]    repl_way,
    output logic [SET_WIDTH-1:0]    way_sel,
    output logic [INDEX_WIDTH-1:0]  arr_index,
    output logic [OFFSET_WIDTH-1:0] arr_word_off,
    input  logic                    victim_valid,
    input  logic                    victim_dirty,
    input  logic [TAG_WIDTH-1:0]    victim_tag,
    input  logic [WORD_WIDTH-1:0]   arr_rdata,
    output logic                    arr_we,
    output logic [WORD_WIDTH-1:0]   arr_wdata,
    output logic                    tag_we,
    output logic [TAG_WIDTH-1:0]    tag_wdata,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    input  logic [WORD_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_ready
);

    typedef enum logic [2:0] {
        IDLE, SELECT, CHECK, WB, FILL, UPDATE, DONE
    } state_t;

    state_t                  state;
    logic [OFFSET_WIDTH-1:0] k;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [INDEX_WIDTH-1:0]  index_q;
    logic [SET_WIDTH-1:0]    way_q;
    logic                    last_word;

    assign last_word = (k == {OFFSET_WIDTH{1'b1}});

    // NOTE: every state bit and registered output updates with <= so all of them see
    // the pre-edge values; blocking here would let later statements read new state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            k           <= '0;
            tag_q       <= '0;
            index_q     <= '0;
            way_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            repl_en     <= 1'b0;
            repl_update <= 1'b0;
            mem_req     <= 1'b0;
            tag_we      <= 1'b0;
        end else begin
            // Single-cycle strobes default low and are raised only on the transition into their state.
            done        <= 1'b0;
            repl_en     <= 1'b0;
            repl_update <= 1'b0;
            tag_we      <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    tag_q   <= miss_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
                    index_q <= miss_addr[OFFSET_WIDTH +: INDEX_WIDTH];
                    busy    <= 1'b1;
                    repl_en <= 1'b1;
                    state   <= SELECT;
                end
                SELECT: begin
                    way_q <= repl_way;
                    state <= CHECK;
                end
                CHECK: begin
                    mem_req <= 1'b1;
`ifdef CMH_WRITEBACK_EN
                    if (victim_valid && victim_dirty) state <= WB;
                    else                              state <= FILL;
`else
                    state <= FILL;
`endif
                end
`ifdef CMH_WRITEBACK_EN
                WB: if (mem_ready) begin
                    k <= k + 1'b1;
                    if (last_word) state <= FILL;
                end
`endif
                FILL: if (mem_ready) begin
                    k <= k + 1'b1;
                    if (last_word) begin
                        mem_req     <= 1'b0;
                        tag_we      <= 1'b1;
                        repl_update <= 1'b1;
                        state       <= UPDATE;
                    end
                end
                UPDATE: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CMH_WRITEBACK_EN
    logic [TAG_WIDTH-1:0] victim_tag_q;
    logic                 unused_bits;

    // The victim tag is frozen at CHECK so the write-back address cannot drift.
    always_ff @(posedge clk) begin
        if (!rst)                victim_tag_q <= '0;
        else if (state == CHECK) victim_tag_q <= victim_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst)                             mem_we <= 1'b0;
        else if (state == CHECK)              mem_we <= victim_valid && victim_dirty;
        else if (state == WB && mem_ready && last_word) mem_we <= 1'b0;
    end

    assign mem_addr  = (state == WB) ? {victim_tag_q, index_q, k} : {tag_q, index_q, k};
    assign mem_wdata = mem_we ? arr_rdata : '0;
    assign unused_bits = ^miss_addr[OFFSET_WIDTH-1:0];
`else
    logic unused_bits;

    assign mem_we    = 1'b0;
    assign mem_addr  = {tag_q, index_q, k};
    assign mem_wdata = '0;
    assign unused_bits = ^{miss_addr[OFFSET_WIDTH-1:0], victim_valid, victim_dirty,
                           victim_tag, arr_rdata};
`endif

    assign repl_hit     = 1'b0;
    assign repl_index   = index_q;
    assign way_sel      = way_q;
    assign arr_index    = index_q;
    assign arr_word_off = k;
    assign tag_wdata    = tag_q;
    assign arr_we       = (state == FILL) && mem_ready;
    assign arr_wdata    = arr_we ? mem_rdata : '0;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler; expectations follow the build's CMH_WRITEBACK_EN setting.
module tb_cache_miss_handler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] miss_addr = '0;
    logic        busy, done, repl_en, repl_update, repl_hit;
    logic [7:0]  repl_index, arr_index;
    logic [1:0]  repl_way = 2'd2;
    logic [1:0]  way_sel, arr_word_off;
    logic        victim_valid = 1'b0, victim_dirty = 1'b0;
    logic [5:0]  victim_tag = '0;
    logic [15:0] arr_rdata, arr_wdata;
    logic        arr_we, tag_we;
    logic [5:0]  tag_wdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory returns a scrambled address; the array returns 0xD000 + word offset.
    assign mem_rdata = mem_addr ^ 16'h5A5A;
    assign arr_rdata = {14'h3400, arr_word_off};

    cache_miss_handler dut (
        .clk(clk), .rst(rst), .start(start), .miss_addr(miss_addr),
        .busy(busy), .done(done), .repl_en(repl_en), .repl_update(repl_update),
        .repl_hit(repl_hit), .repl_index(repl_index), .repl_way(repl_way),
        .way_sel(way_sel), .arr_index(arr_index), .arr_word_off(arr_word_off),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .arr_rdata(arr_rdata), .arr_we(arr_we), .arr_wdata(arr_wdata),
        .tag_we(tag_we), .tag_wdata(tag_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

`ifdef CMH_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    // Observations gathered by the service run
    logic [15:0] rd_addr[$], wr_addr[$], wr_data[$], aw_data[$];
    logic [1:0]  aw_off[$];
    int   upd_cnt, tagwe_cnt, done_cnt, done_cyc, hit_seen, order_bad, unstable, mem_we_seen;
    logic [7:0]  upd_idx, repl_idx1;
    logic [5:0]  tag_val;
    logic [1:0]  way2;
    logic        busy1, repl_en1, busy_at_done, busy_after, req_after_abort, busy_after_abort;

    // Issues one miss (start accepted at edge 0) and samples every cycle n at the negedge.
    task automatic service(input logic [15:0] addr, input int waits, input int poke_at,
                           input int abort_at, input int tail);
        int n = 0, wc = 0, after = 0;
        logic prev_req = 1'b0, prev_xfer = 1'b0, xfer;
        logic [15:0] prev_addr = '0, prev_wdata = '0;
        rd_addr.delete(); wr_addr.delete(); wr_data.delete(); aw_data.delete(); aw_off.delete();
        upd_cnt = 0; tagwe_cnt = 0; done_cnt = 0; done_cyc = -1; hit_seen = 0;
        order_bad = 0; unstable = 0; mem_we_seen = 0;
        upd_idx = 'x; tag_val = 'x; busy_at_done = 1'bx; busy_after = 1'bx;
        @(negedge clk);
        miss_addr = addr;
        start = 1'b1;
        mem_ready = (waits == 0);
        @(posedge clk);
        while (1) begin
            @(negedge clk);
            n++;
            start = (n == poke_at);
            if (n == 1) begin busy1 = busy; repl_en1 = repl_en; repl_idx1 = repl_index; end
            if (n == 2) way2 = way_sel;
            if (abort_at > 0 && n == abort_at + 1) begin
                req_after_abort = mem_req; busy_after_abort = busy; rst = 1'b1;
            end
            if (abort_at > 0 && n == abort_at) rst = 1'b0;
            if (waits == 0) mem_ready = 1'b1;
            else if (mem_req && wc == waits) begin mem_ready = 1'b1; wc = 0; end
            else begin mem_ready = 1'b0; if (mem_req) wc++; end
            #1;
            if (mem_req && prev_req && !prev_xfer &&
                (mem_addr !== prev_addr || (mem_we && mem_wdata !== prev_wdata))) unstable++;
            xfer = mem_req && mem_ready;
            if (xfer && mem_we) begin
                wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata);
                if (rd_addr.size() != 0) order_bad++;
            end else if (xfer) rd_addr.push_back(mem_addr);
            if (arr_we) begin aw_data.push_back(arr_wdata); aw_off.push_back(arr_word_off); end
            if (repl_update) begin upd_cnt++; upd_idx = repl_index; if (repl_hit) hit_seen++; end
            if (tag_we) begin tagwe_cnt++; tag_val = tag_wdata; end
            if (mem_we) mem_we_seen++;
            if (n == done_cyc + 1 && done_cyc > 0) busy_after = busy;
            if (done) begin done_cnt++; done_cyc = n; busy_at_done = busy; end
            prev_req = mem_req; prev_xfer = xfer; prev_addr = mem_addr; prev_wdata = mem_wdata;
            if (done_cnt > 0 || (abort_at > 0 && n > abort_at)) after++;
            if (after > tail || n >= 300) break;
        end
        start = 1'b0;
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done, repl_en, repl_update, repl_hit, arr_we, tag_we, mem_req, mem_we} !== 9'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 000000000",
                     {busy, done, repl_en, repl_update, repl_hit, arr_we, tag_we, mem_req, mem_we});
        end
        checks++;
        if ({mem_addr, mem_wdata, arr_wdata, repl_index, way_sel, tag_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: mem_addr=%h mem_wdata=%h arr_wdata=%h idx=%h way=%h tag=%h required 0",
                     mem_addr, mem_wdata, arr_wdata, repl_index, way_sel, tag_wdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_clean_miss();
        victim_valid = 1'b0; victim_dirty = 1'b1; victim_tag = 6'h15; repl_way = 2'd2;
        service(16'h1234, 0, 0, 0, 2);
        checks++;
        if ({busy1, repl_en1} !== 2'b11) begin
            errors++; $display("FAIL clean_select: busy/repl_en=%b required 11", {busy1, repl_en1});
        end
        checks++;
        if (repl_idx1 !== 8'h8D) begin errors++; $display("FAIL clean_repl_index: got %h required 8d", repl_idx1); end
        checks++;
        if (way2 !== 2'd2) begin errors++; $display("FAIL clean_way_sel: got %0d required 2", way2); end
        checks++;
        if (rd_addr.size() != 4 || wr_addr.size() != 0) begin
            errors++; $display("FAIL clean_xfer_count: reads=%0d writes=%0d required 4/0", rd_addr.size(), wr_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_addr[i] !== 16'h1234 + 16'(i)) begin
                errors++; $display("FAIL clean_rd_addr%0d: got %h required %h", i, rd_addr[i], 16'h1234 + 16'(i));
            end
            checks++;
            if (aw_data[i] !== ((16'h1234 + 16'(i)) ^ 16'h5A5A) || aw_off[i] !== 2'(i)) begin
                errors++; $display("FAIL clean_arr_write%0d: data=%h off=%0d required %h/%0d",
                                   i, aw_data[i], aw_off[i], (16'h1234 + 16'(i)) ^ 16'h5A5A, i);
            end
        end
        checks++;
        if (tagwe_cnt != 1 || tag_val !== 6'h04) begin
            errors++; $display("FAIL clean_tag: count=%0d tag=%h required 1/04", tagwe_cnt, tag_val);
        end
        checks++;
        if (upd_cnt != 1 || upd_idx !== 8'h8D || hit_seen != 0) begin
            errors++; $display("FAIL clean_update: count=%0d idx=%h hits=%0d required 1/8d/0", upd_cnt, upd_idx, hit_seen);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 8) begin
            errors++; $display("FAIL clean_done: count=%0d cycle=%0d required 1/8", done_cnt, done_cyc);
        end
        checks++;
        if (busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
            errors++; $display("FAIL clean_busy: at_done=%b after=%b required 1/0", busy_at_done, busy_after);
        end
    endtask

    task automatic test_dirty_miss();
        victim_valid = 1'b1; victim_dirty = 1'b1; victim_tag = 6'h3F; repl_way = 2'd1;
        service(16'h0400, 0, 0, 0, 1);
        checks++;
        if (wr_addr.size() != (WB_EN ? 4 : 0) || rd_addr.size() != 4) begin
            errors++; $display("FAIL dirty_xfer_count: writes=%0d reads=%0d required %0d/4",
                               wr_addr.size(), rd_addr.size(), WB_EN ? 4 : 0);
        end
        if (WB_EN) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr[i] !== 16'hFC00 + 16'(i) || wr_data[i] !== 16'hD000 + 16'(i)) begin
                    errors++; $display("FAIL dirty_wb%0d: addr=%h data=%h required %h/%h",
                                       i, wr_addr[i], wr_data[i], 16'hFC00 + 16'(i), 16'hD000 + 16'(i));
                end
            end
            checks++;
            if (order_bad != 0) begin errors++; $display("FAIL dirty_order: %0d writes after reads required 0", order_bad); end
        end else begin
            checks++;
            if (mem_we_seen != 0) begin errors++; $display("FAIL dirty_mem_we: high %0d cycles required 0", mem_we_seen); end
        end
        checks++;
        if (rd_addr[0] !== 16'h0400 || rd_addr[3] !== 16'h0403) begin
            errors++; $display("FAIL dirty_fill_addr: first=%h last=%h required 0400/0403", rd_addr[0], rd_addr[3]);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != (WB_EN ? 12 : 8)) begin
            errors++; $display("FAIL dirty_done: count=%0d cycle=%0d required 1/%0d", done_cnt, done_cyc, WB_EN ? 12 : 8);
        end
    endtask

    task automatic test_wait_states();
        victim_valid = 1'b0; victim_dirty = 1'b0;
        service(16'h5678, 3, 0, 0, 1);
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL wait_stable: %0d changes while stalled required 0", unstable); end
        checks++;
        if (rd_addr.size() != 4 || rd_addr[0] !== 16'h5678 || rd_addr[3] !== 16'h567B) begin
            errors++; $display("FAIL wait_reads: count=%0d first=%h last=%h required 4/5678/567b",
                               rd_addr.size(), rd_addr[0], rd_addr[3]);
        end
        checks++;
        if (aw_data.size() != 4) begin errors++; $display("FAIL wait_arr_we: got %0d required 4", aw_data.size()); end
        checks++;
        if (done_cyc != 20) begin errors++; $display("FAIL wait_done: cycle=%0d required 20", done_cyc); end
    endtask

    task automatic test_abort();
        victim_valid = 1'b0;
        service(16'h1234, 0, 0, 5, 4);
        checks++;
        if (req_after_abort !== 1'b0 || busy_after_abort !== 1'b0) begin
            errors++; $display("FAIL abort_outputs: mem_req=%b busy=%b required 0/0", req_after_abort, busy_after_abort);
        end
        checks++;
        if (upd_cnt != 0 || done_cnt != 0 || tagwe_cnt != 0) begin
            errors++; $display("FAIL abort_no_finish: update=%0d done=%0d tag_we=%0d required 0/0/0", upd_cnt, done_cnt, tagwe_cnt);
        end
        service(16'h2468, 0, 0, 0, 1);
        checks++;
        if (done_cyc != 8 || upd_cnt != 1 || rd_addr[0] !== 16'h2468) begin
            errors++; $display("FAIL abort_recover: done_cycle=%0d update=%0d first=%h required 8/1/2468",
                               done_cyc, upd_cnt, rd_addr[0]);
        end
    endtask

    task automatic test_busy_start();
        victim_valid = 1'b1; victim_dirty = 1'b1; victim_tag = 6'h2A;
        service(16'h8000, 0, 4, 0, 6);
        checks++;
        if (done_cnt != 1 || upd_cnt != 1) begin
            errors++; $display("FAIL busy_start: done=%0d update=%0d required 1/1", done_cnt, upd_cnt);
        end
        checks++;
        if (done_cyc != (WB_EN ? 12 : 8)) begin
            errors++; $display("FAIL busy_start_latency: cycle=%0d required %0d", done_cyc, WB_EN ? 12 : 8);
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_dirty_miss();
        test_wait_states();
        test_abort();
        test_busy_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Miss-service engine for the set-associative write-back/write-allocate data cache. It is the initiator side of the FIFO replacement interface: on a miss it queries the replacement unit for a victim way and writes the victim back to memory if it is dirty. It then fills the line from memory, installs the new tag, and pulses the replacement unit's update strobe. It sits between the cache hit/miss controller, the tag/data arrays and the memory bus.

## Interface
Parameters:
- INDEX_WIDTH, 8, set index width (256 sets)
- SET_WIDTH, 2, way-select width (4 ways)
- OFFSET_WIDTH, 2, word offset width (4 words per line)
- TAG_WIDTH, 6, tag width; TAG+INDEX+OFFSET = 16-bit address
- WORD_WIDTH, 16, data word width

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-low reset
- start  in  1  miss request, sampled only in IDLE
- miss_addr  in  16  missing word address, latched on accepted start
- busy  out  1  high from the cycle after start is accepted until DONE inclusive
- done  out  1  one-cycle pulse: line installed
- repl_en  out  1  enables replacement unit output
- repl_update  out  1  replacement history advance strobe
- repl_hit  out  1  always 0 (handler only services misses)
- repl_index  out  INDEX_WIDTH  index to replacement unit
- repl_way  in  SET_WIDTH  victim way from replacement unit
- way_sel  out  SET_WIDTH  latched victim way to arrays
- arr_index  out  INDEX_WIDTH  array index
- arr_word_off  out  OFFSET_WIDTH  array word offset
- victim_valid, victim_dirty  in  1 each  status of arrays at (arr_index, way_sel)
- victim_tag  in  TAG_WIDTH  tag at (arr_index, way_sel)
- arr_rdata  in  WORD_WIDTH  combinational array read at (arr_index, way_sel, arr_word_off)
- arr_we  out  1  data word write
- arr_wdata  out  WORD_WIDTH  data word to arrays
- tag_we  out  1  write tag, set valid=1, dirty=0
- tag_wdata  out  TAG_WIDTH  new tag
- mem_req, mem_we  out  1 each  memory request / write qualifier
- mem_addr  out  16  memory word address
- mem_wdata  out  WORD_WIDTH  write data
- mem_rdata  in  WORD_WIDTH  read data, valid when mem_ready
- mem_ready  in  1  completes current word transfer

## Operation
- States: IDLE, SELECT, CHECK, WB, FILL, UPDATE, DONE.
- IDLE: start=1 latches tag/index from miss_addr and goes to SELECT. start while not IDLE is ignored and not queued.
- SELECT (1 cycle): repl_en=1, repl_index=latched index. repl_way is captured into way_sel at the cycle end. Go to CHECK.
- CHECK (1 cycle): victim_valid && victim_dirty goes to WB; otherwise FILL. An invalid victim is clean regardless of victim_dirty.
- WB: word counter k runs 0..3. mem_req=1, mem_we=1, mem_addr={victim_tag, index, k}, arr_word_off=k, mem_wdata=arr_rdata. On mem_ready, k increments. After k=3 completes, clear k and go to FILL.
- FILL: mem_req=1, mem_we=0, mem_addr={new tag, index, k}, arr_word_off=k. On mem_ready: arr_we=1, arr_wdata=mem_rdata, and k increments. After k=3 go to UPDATE.
- UPDATE (1 cycle): tag_we=1, tag_wdata=new tag, repl_update=1, repl_hit=0, repl_index=index. Go to DONE.
- DONE (1 cycle): done=1, then IDLE.
- Counter k wraps 3 to 0 on phase exit. The word order is always ascending; there is no critical-word-first.
- mem_ready while mem_req=0 is ignored.

## Timing
- Reset (rst=0 at a posedge): state IDLE, k=0. All outputs are 0 in the following cycle, including mem_req. This applies mid-transfer: the request is abandoned, and no update or done is issued.
- busy/done/repl_* and array/memory controls are decoded from registered state (Moore). arr_we/arr_wdata in FILL are combinational on mem_ready.
- mem_req stays high, with address and data stable, until the cycle mem_ready=1. Back-to-back words are allowed (mem_req stays high and the address advances).
- Latency, mem_ready tied high, start accepted at edge 0: clean miss gives done in cycle 8 (SELECT 1, CHECK 2, FILL 3–6, UPDATE 7, DONE 8). Dirty miss gives done in cycle 12.
- Each memory wait cycle adds one cycle.
- repl_update is exactly one cycle per serviced miss.

## Configuration
- CMH_WRITEBACK_EN defined: behaviour as above.
- Undefined: the WB state and the mem_we=1 path are removed. CHECK always goes to FILL, victim_dirty/victim_tag are ignored, and mem_we is constant 0 (write-through caches). Latency is always the clean-miss figure.

## Test plan
- Reset: hold rst=0 for 2 cycles -> all outputs 0, busy=0.
- Clean miss: miss_addr=16'h1234, repl_way=2, victim_valid=0, mem_ready=1 -> 4 reads at 16'h1234..16'h1237 (word 0 first), 4 arr_we, then tag_we with tag 6'h04, one repl_update with index 8'h8D, done at cycle 8.
- Dirty miss: victim_valid=1, victim_dirty=1, victim_tag=6'h3F, index 8'h00 -> writes to 16'hFC00..16'hFC03 precede the reads, done at cycle 12.
- Wait states: mem_ready low for 3 cycles on each word -> address/data held stable, done at cycle 20 (clean).
- Abort: rst=0 during FILL word 2 -> mem_req=0 next cycle, no repl_update/done, next start serviced normally.
- Busy start: start pulses during WB -> ignored, exactly one done.
